// File: rtl/dm_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dm_arbiter_if                                                   |
// | Brief    : Requester-side request/response bundle for the data-memory      |
// |            arbiter (one instance per requester).                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface dm_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata, pc,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata, pc,
        output ack, err, rdata
    );
endinterface
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dm_arbiter                                                      |
// | Brief    : Two-requester arbiter/sequencer for a word-wide single-port     |
// |            data memory; partial writes become read-modify-write.          |
// |            Optional: DM_ARB_FIXED_PRIO_EN (m0 always wins contention).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dm_arbiter #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    dm_arbiter_if.slave      m0,
    dm_arbiter_if.slave      m1,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wd_o,
    output logic [31:0]      mem_pc_o,
    input  wire logic [31:0] mem_rd_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_MERGE  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        gnt_q;
    logic        we_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [31:0] merge_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic        w_any;
    logic        w_sel;
    logic        w_sel_we;
    logic [29:0] w_sel_addr;
    logic [3:0]  w_sel_be;
    logic [31:0] w_sel_wdata;
    logic [31:0] w_sel_pc;
    logic        w_oor;
    logic        w_full;
    logic        w_none;
    logic [31:0] w_merged;
    logic        w_unused_addr_lsb;

    // Byte offsets never reach the memory; the word index alone is latched.
    assign w_unused_addr_lsb = ^{m0.addr[1:0], m1.addr[1:0]};

    assign w_any = m0.req | m1.req;

`ifdef DM_ARB_FIXED_PRIO_EN
    assign w_sel = ~m0.req;
`else
    logic prio_q, prio_d;

    always_comb begin
        w_sel = m1.req;
        if (m0.req && m1.req) begin
            w_sel = prio_q;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (state_q == S_RESP) begin
            prio_d = ~gnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign w_sel_we    = w_sel ? m1.we          : m0.we;
    assign w_sel_addr  = w_sel ? m1.addr[31:2]  : m0.addr[31:2];
    assign w_sel_be    = w_sel ? m1.be          : m0.be;
    assign w_sel_wdata = w_sel ? m1.wdata       : m0.wdata;
    assign w_sel_pc    = w_sel ? m1.pc          : m0.pc;

    assign w_oor  = ({2'b00, addr_q} >= MEM_WORDS);
    assign w_full = (be_q == 4'hF);
    assign w_none = (be_q == 4'h0);

    for (genvar i = 0; i < 4; i++) begin : g_merge
        assign w_merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : merge_q[8*i +: 8];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_oor || !we_q || w_full || w_none) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_MERGE;
                end
            end
            S_MERGE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
            merge_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && w_any) begin
                gnt_q   <= w_sel;
                we_q    <= w_sel_we;
                addr_q  <= w_sel_addr;
                be_q    <= w_sel_be;
                wdata_q <= w_sel_wdata;
                pc_q    <= w_sel_pc;
            end
            if (state_q == S_ACCESS) begin
                // An erroring read returns zero rather than stale data.
                if (w_oor) begin
                    if (!we_q) begin
                        if (gnt_q) rdata1_q <= '0;
                        else       rdata0_q <= '0;
                    end
                end else if (!we_q) begin
                    if (gnt_q) rdata1_q <= mem_rd_i;
                    else       rdata0_q <= mem_rd_i;
                end else if (!w_full && !w_none) begin
                    merge_q <= mem_rd_i;
                end
            end
        end
    end

    // Write strobe decodes from state so an asynchronous reset kills it at once.
    assign mem_we_o   = (state_q == S_MERGE) ||
                        ((state_q == S_ACCESS) && we_q && !w_oor && w_full);
    assign mem_wd_o   = (state_q == S_MERGE) ? w_merged : wdata_q;
    assign mem_addr_o = {addr_q, 2'b00};
    assign mem_pc_o   = pc_q;

    assign m0.ack   = (state_q == S_RESP) && !gnt_q;
    assign m1.ack   = (state_q == S_RESP) &&  gnt_q;
    assign m0.err   = (state_q == S_RESP) && !gnt_q && w_oor;
    assign m1.err   = (state_q == S_RESP) &&  gnt_q && w_oor;
    assign m0.rdata = rdata0_q;
    assign m1.rdata = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dm_arbiter                                                   |
// | Brief    : Self-checking bench for dm_arbiter with a latency-rule model.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dm_arbiter;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if u_m0 ();
    dm_arbiter_if u_m1 ();

    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_pc, mem_rd;

    dm_arbiter #(.MEM_WORDS(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0         (u_m0),
        .m1         (u_m1),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wd_o   (mem_wd),
        .mem_pc_o   (mem_pc),
        .mem_rd_i   (mem_rd)
    );

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    assign mem_rd = (mem_addr[31:12] == 20'd0) ? mem[mem_addr[11:2]] : 32'hBAD0BAD0;
    always @(posedge clk) if (mem_we && mem_addr[31:12] == 20'd0) mem[mem_addr[11:2]] <= mem_wd;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mdl_en = 1'b0;
    bit chk_en = 1'b0;
    int free_at = 0;
    int prio = 0;

    bit          exp_ack [0:1][0:MAXC-1];
    bit          exp_err [0:1][0:MAXC-1];
    bit          exp_rdv [0:1][0:MAXC-1];
    logic [31:0] exp_rd  [0:1][0:MAXC-1];
    bit          exp_we  [0:MAXC-1];
    logic [31:0] exp_wd  [0:MAXC-1];
    bit          exp_av  [0:MAXC-1];
    logic [31:0] exp_addr[0:MAXC-1];
    logic [31:0] exp_pc  [0:MAXC-1];

    int          dut_grants[$];
    int          we_cnt = 0;
    logic [31:0] last_we_wd, last_we_addr, last_we_pc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: no ack within bound (cycle %0d)", nm, cyc);
    endtask

    task automatic clear_exp(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (i >= 0 && i < MAXC) begin
                for (int m = 0; m < 2; m++) begin
                    exp_ack[m][i] = 1'b0; exp_err[m][i] = 1'b0; exp_rdv[m][i] = 1'b0;
                end
                exp_we[i] = 1'b0; exp_av[i] = 1'b0;
            end
        end
    endtask

    // Transaction-level model: a request sampled at edge e shows its ACCESS
    // cycle after e, a partial write's merge after e+1, and the ack after the
    // last of those; the next sample can happen one cycle after the ack.
    initial begin : model
        int e, w, idx, ai;
        bit r0, r1, we_f, oor, part;
        logic [31:0] addr_f, wd_f, pc_f, old, mrg;
        logic [3:0]  be_f;
        forever begin
            @(posedge clk);
            e = cyc;
            cyc = cyc + 1;
            if (mdl_en && rst_n && e >= free_at && e + 4 < MAXC) begin
                r0 = u_m0.req;
                r1 = u_m1.req;
                if (r0 || r1) begin
`ifdef DM_ARB_FIXED_PRIO_EN
                    w = r0 ? 0 : 1;
`else
                    w = (r0 && r1) ? prio : (r0 ? 0 : 1);
`endif
                    we_f   = (w == 0) ? u_m0.we    : u_m1.we;
                    addr_f = (w == 0) ? u_m0.addr  : u_m1.addr;
                    be_f   = (w == 0) ? u_m0.be    : u_m1.be;
                    wd_f   = (w == 0) ? u_m0.wdata : u_m1.wdata;
                    pc_f   = (w == 0) ? u_m0.pc    : u_m1.pc;
                    oor    = (addr_f[31:2] >= 30'd1024);
                    idx    = int'(addr_f[11:2]);
                    part   = we_f && !oor && be_f != 4'hF && be_f != 4'h0;
                    ai     = part ? e + 2 : e + 1;
                    exp_av[e] = 1'b1;
                    exp_addr[e] = {addr_f[31:2], 2'b00};
                    exp_pc[e] = pc_f;
                    exp_ack[w][ai] = 1'b1;
                    exp_err[w][ai] = oor;
                    if (!we_f) begin
                        exp_rdv[w][ai] = 1'b1;
                        exp_rd[w][ai]  = oor ? 32'h0 : ref_mem[idx];
                    end else if (!oor && be_f == 4'hF) begin
                        exp_we[e] = 1'b1;
                        exp_wd[e] = wd_f;
                        ref_mem[idx] = wd_f;
                    end else if (part) begin
                        old = ref_mem[idx];
                        for (int b = 0; b < 4; b++)
                            mrg[8*b +: 8] = be_f[b] ? wd_f[8*b +: 8] : old[8*b +: 8];
                        exp_we[e+1] = 1'b1;
                        exp_wd[e+1] = mrg;
                        exp_av[e+1] = 1'b1;
                        exp_addr[e+1] = {addr_f[31:2], 2'b00};
                        exp_pc[e+1] = pc_f;
                        ref_mem[idx] = mrg;
                    end
                    prio = 1 - w;
                    free_at = part ? e + 4 : e + 3;
                end
            end
        end
    end

    initial begin : compare
        int i;
        forever begin
            @(negedge clk);
            if (u_m0.ack) dut_grants.push_back(0);
            if (u_m1.ack) dut_grants.push_back(1);
            if (mem_we) begin
                we_cnt++;
                last_we_wd = mem_wd; last_we_addr = mem_addr; last_we_pc = mem_pc;
            end
            i = cyc - 1;
            if (chk_en && i >= 0 && i < MAXC) begin
                check("m0_ack", 32'(u_m0.ack), 32'(exp_ack[0][i]));
                check("m1_ack", 32'(u_m1.ack), 32'(exp_ack[1][i]));
                check("m0_err", 32'(u_m0.err), 32'(exp_err[0][i]));
                check("m1_err", 32'(u_m1.err), 32'(exp_err[1][i]));
                check("mem_we", 32'(mem_we), 32'(exp_we[i]));
                if (exp_we[i]) check("mem_wd", mem_wd, exp_wd[i]);
                if (exp_av[i]) begin
                    check("mem_addr", mem_addr, exp_addr[i]);
                    check("mem_pc", mem_pc, exp_pc[i]);
                end
                if (exp_rdv[0][i] && u_m0.ack) check("m0_rdata", u_m0.rdata, exp_rd[0][i]);
                if (exp_rdv[1][i] && u_m1.ack) check("m1_rdata", u_m1.rdata, exp_rd[1][i]);
            end
        end
    end

    task automatic drive(input int m, input logic rq, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input logic [31:0] pc);
        if (m == 0) begin
            u_m0.req = rq; u_m0.we = we; u_m0.addr = addr; u_m0.be = be; u_m0.wdata = wd; u_m0.pc = pc;
        end else begin
            u_m1.req = rq; u_m1.we = we; u_m1.addr = addr; u_m1.be = be; u_m1.wdata = wd; u_m1.pc = pc;
        end
    endtask

    task automatic setreq(input int m, input logic v);
        if (m == 0) u_m0.req = v;
        else        u_m1.req = v;
    endtask

    task automatic do_xact(input int m, input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] pc,
                           output int lat, output logic [31:0] rd, output logic er);
        int t0;
        bit got;
        got = 1'b0; lat = -1; rd = 32'hX; er = 1'bX;
        @(posedge clk); #1;
        drive(m, 1'b1, we, addr, be, wd, pc);
        t0 = cyc;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if ((m == 0) ? u_m0.ack : u_m1.ack) begin
                got = 1'b1;
                lat = cyc - t0;
                rd  = (m == 0) ? u_m0.rdata : u_m1.rdata;
                er  = (m == 0) ? u_m0.err : u_m1.err;
            end
        end
        if (!got) timeout_fail("directed_ack");
        @(posedge clk); #1;
        setreq(m, 1'b0);
    endtask

    task automatic drive_rand(input int m, input int n);
        int gap;
        bit got;
        logic [31:0] addr;
        logic [3:0]  be;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                setreq(m, 1'b0);
                repeat (gap) begin @(posedge clk); #1; end
            end
            if ($urandom_range(0, 9) == 0)
                addr = {$urandom_range(1024, 1100), 2'($urandom_range(0, 3))};
            else
                addr = {$urandom_range(0, 31), 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 3))
                0:       be = 4'hF;
                1:       be = 4'h0;
                default: be = 4'($urandom_range(0, 15));
            endcase
            drive(m, 1'b1, 1'($urandom_range(0, 1)), addr, be, $urandom, $urandom);
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if ((m == 0) ? u_m0.ack : u_m1.ack) got = 1'b1;
            end
            if (!got) timeout_fail("random_ack");
            @(posedge clk); #1;
        end
        setreq(m, 1'b0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time bound");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, n0, w0, acks, bad;
        logic [31:0] rd;
        logic er;
        int exp_g[6];

        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        clear_exp(0, MAXC - 1);
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_m0_ack", 32'(u_m0.ack), 32'h0);
        check("rst_m1_ack", 32'(u_m1.ack), 32'h0);
        check("rst_err", 32'({u_m0.err, u_m1.err}), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_mem_pc", mem_pc, 32'h0);
        check("rst_rdata", u_m0.rdata | u_m1.rdata, 32'h0);
        rst_n = 1'b1;
        free_at = cyc; prio = 0; mdl_en = 1'b1; chk_en = 1'b1;

        mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
        w0 = we_cnt;
        do_xact(0, 1'b0, 32'h40, 4'hF, 32'h0, 32'h100, lat, rd, er);
        check("read_lat", lat, 2);
        check("read_data", rd, 32'hDEADBEEF);
        check("read_err", 32'(er), 32'h0);
        check("read_no_we", we_cnt, w0);

        mem[16] = 32'h11223344; ref_mem[16] = 32'h11223344;
        w0 = we_cnt;
        do_xact(1, 1'b1, 32'h41, 4'b0010, 32'h0000AA00, 32'h104, lat, rd, er);
        check("rmw_lat", lat, 3);
        check("rmw_we_once", we_cnt, w0 + 1);
        check("rmw_wd", last_we_wd, 32'h1122AA44);
        check("rmw_mem", mem[16], 32'h1122AA44);

`ifdef DM_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1, 0, 1};
`endif
        n0 = dut_grants.size();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h80, 4'hF, 32'h0, 32'h200);
        drive(1, 1'b1, 1'b0, 32'h84, 4'hF, 32'h0, 32'h204);
        for (int k = 0; k < 60 && dut_grants.size() < n0 + 6; k++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        setreq(0, 1'b0); setreq(1, 1'b0);
        if (dut_grants.size() < n0 + 6) timeout_fail("contention");
        else for (int g = 0; g < 6; g++) check($sformatf("grant%0d", g), dut_grants[n0 + g], exp_g[g]);

        w0 = we_cnt;
        do_xact(0, 1'b0, 32'h00001000, 4'hF, 32'h0, 32'h300, lat, rd, er);
        check("oor_lat", lat, 2);
        check("oor_err", 32'(er), 32'h1);
        check("oor_rdata", rd, 32'h0);
        check("oor_no_we", we_cnt, w0);

        w0 = we_cnt;
        do_xact(0, 1'b1, 32'h8, 4'hF, 32'h12345678, 32'h00003000, lat, rd, er);
        check("fullwr_lat", lat, 2);
        check("fullwr_we_once", we_cnt, w0 + 1);
        check("fullwr_addr", last_we_addr, 32'h8);
        check("fullwr_pc", last_we_pc, 32'h00003000);
        check("fullwr_wd", last_we_wd, 32'h12345678);
        check("fullwr_mem", mem[2], 32'h12345678);

        w0 = we_cnt;
        do_xact(1, 1'b1, 32'hC, 4'h0, 32'hFFFFFFFF, 32'h400, lat, rd, er);
        check("zerobe_lat", lat, 2);
        check("zerobe_no_we", we_cnt, w0);

        // Reset in the middle of a read-modify-write.
        mdl_en = 1'b0; chk_en = 1'b0;
        mem[5] = 32'hCAFEF00D; ref_mem[5] = 32'hCAFEF00D;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h14, 4'b0001, 32'h00000055, 32'h500);
        @(posedge clk); #1;
        setreq(0, 1'b0);
        @(posedge clk); #1;
        check("rst_merge_we", 32'(mem_we), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_async_we", 32'(mem_we), 32'h0);
        check("rst_async_addr", mem_addr, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (u_m0.ack || u_m1.ack) acks++;
        end
        check("rst_no_ack", acks, 0);
        check("rst_word_kept", mem[5], 32'hCAFEF00D);
        @(posedge clk); #1;
        clear_exp(cyc - 1, cyc + 8);
        free_at = cyc; prio = 0; mdl_en = 1'b1; chk_en = 1'b1;
        do_xact(0, 1'b0, 32'h14, 4'hF, 32'h0, 32'h600, lat, rd, er);
        check("post_rst_lat", lat, 2);
        check("post_rst_read", rd, 32'hCAFEF00D);

        fork
            drive_rand(0, 150);
            drive_rand(1, 150);
        join
        repeat (6) @(posedge clk);

        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("final_mem_words_differing", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port, word-wide data memory (1024 x 32, combinational read, synchronous word write).
- Requesters: m0 is the CPU MEM-stage port; m1 is a secondary port (loader/debug/DMA).
- Grants one requester at a time and issues word reads and full-word writes directly.
- Converts partial (byte/halfword) writes into a read-modify-write sequence, because the memory only supports whole-word writes.

Parameters:
- MEM_WORDS, 1024, number of words in memory; word index = addr[31:2]; indices >= MEM_WORDS are out of range.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  request, held until m0_ack.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  32  byte address; bits [1:0] ignored.
- m0_be  in  4  byte enables for writes; bit i selects byte i = wdata[8i+7:8i].
- m0_wdata  in  32  write data, already lane-aligned.
- m0_pc  in  32  PC of the originating instruction, forwarded to memory.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  pulses with m0_ack when the address is out of range.
- m0_rdata  out  32  read data, valid while m0_ack is high.
- m1_*  —  same set as m0_*.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word-aligned address {addr[31:2], 2'b00}.
- mem_wd  out  32  memory write data.
- mem_pc  out  32  PC of the granted request.
- mem_rd  in  32  memory combinational read data.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; prio pointer = 0 (m0 favoured).
  - All acks, errs and mem_we = 0.
  - rdata registers, mem_addr, mem_wd, mem_pc = 0.
  - An in-flight access is abandoned. mem_we decodes from state, so it falls immediately and no partial word is written.
- State IDLE:
  - Sample m0_req and m1_req.
  - One requesting: grant it.
  - Both requesting: grant the one selected by the prio pointer.
  - Latch we, addr, be, wdata, pc of the winner and go to ACCESS.
  - No request: stay in IDLE with mem_we = 0.
- State ACCESS:
  - mem_addr and mem_pc are driven from the latched values.
  - Out of range: no memory access; go to RESP with err set.
  - Read: capture mem_rd into the winner's rdata; go to RESP.
  - Write, be = 4'hF: mem_we = 1, mem_wd = wdata; go to RESP.
  - Write, be = 4'h0: no write; go to RESP.
  - Write, other be: capture mem_rd into the merge register; go to MERGE.
- State MERGE:
  - mem_we = 1.
  - mem_wd byte i = be[i] ? wdata byte i : merge byte i.
  - Go to RESP.
- State RESP:
  - Winner's ack = 1 for exactly one cycle; err likewise when applicable.
  - rdata is held from ACCESS.
  - prio pointer = the other requester (round-robin); go to IDLE.
- Latency, measured from the IDLE sampling edge (cycle 0):
  - read, full write, zero-be write and error: ack in cycle 2.
  - partial write: ack in cycle 3.
- Throughput: at most one transaction every 3 cycles (4 for partial writes).
- Handshake rules:
  - Requests are sampled only in IDLE.
  - Changes to a requester's inputs after the IDLE sample are ignored until its ack.
  - A req still high in the IDLE cycle after ack is a new request.
  - The losing requester simply waits; its req must stay high.
- Simultaneous events:
  - Both requesters win alternately under continuous contention.
  - A request arriving during ACCESS/MERGE/RESP waits for IDLE.
- mem_we is asserted for exactly one cycle per write transaction. It is never asserted in IDLE or RESP.

Optional Feature:
- Macro: DM_ARB_FIXED_PRIO_EN.
  - Defined: m0 always wins contention, and the prio pointer is not implemented (m1 can starve).
  - Undefined: round-robin as specified above.

Test Plan:
- Read m0: mem word 0x10 = 0xDEADBEEF; m0 reads addr 0x40 → m0_ack 2 cycles after the sample, m0_rdata = 0xDEADBEEF, mem_we never high.
- Byte write (RMW): word 0x10 = 0x11223344; m1 writes addr 0x41, be = 4'b0010, wdata = 0x0000AA00 → ACCESS then MERGE; mem_wd = 0x1122AA44 with mem_we high one cycle; m1_ack in cycle 3.
- Contention: m0 and m1 both held high for 6 transactions → grants alternate m0, m1, m0, …; with DM_ARB_FIXED_PRIO_EN, all m0.
- Out of range: m0 reads addr 0x00001000 (index 1024) → m0_ack and m0_err pulse together, mem_we = 0, m0_rdata = 0.
- Reset mid-RMW: assert reset low during MERGE → mem_we drops asynchronously; word unchanged; state IDLE; no ack after release.
- Full write with PC: m0 writes 0x00003000 (pc) / addr 0x8, be = F, data 0x12345678 → one-cycle mem_we, mem_addr = 0x8, mem_pc = 0x00003000, mem_wd = 0x12345678.
